// File: rtl/shifter_req_arb.sv
// Packet-level round-robin arbiter feeding one shifter input port from NUM_REQ requesters,
// with an ID FIFO naming the owner of each packet emerging from the shifter.
module shifter_req_arb #(
    parameter int NUM_REQ       = 4,
    parameter int DIN_WIDTH     = 256,
    parameter int DIN_BCNT      = 6,
    parameter int IDW           = 2,
    parameter int ID_FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]  req_data,
    input  logic [NUM_REQ*2-1:0]          req_sbcnt_hdr,
    input  logic [NUM_REQ*DIN_BCNT-1:0]   req_bcnt,
    input  logic [NUM_REQ-1:0]            req_eop,
    input  logic [NUM_REQ-1:0]            req_vld,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic [DIN_WIDTH-1:0]          shf_data_in,
    output logic [1:0]                    shf_sbcnt_hdr,
    output logic [DIN_BCNT-1:0]           shf_bcnt,
    output logic                          shf_eop,
    output logic                          shf_vld,
    input  logic                          shf_rdy,
    input  logic                          shf_out_eop_acc,
    output logic [IDW-1:0]                out_id,
    output logic                          out_id_vld,
    output logic                          busy
);
    localparam int PW = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic            first_beat_q, first_beat_d;

    logic [IDW-1:0]  fifo_mem_q [ID_FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;

    logic            fifo_full, fifo_empty, push, pop;
    logic            pick_found;
    logic [IDW-1:0]  pick_id;
    int unsigned     scan_idx;

    function automatic logic [IDW-1:0] next_rr(input logic [IDW-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : IDW'(int'(id) + 1);
    endfunction

    assign fifo_full  = (cnt_q == CW'(ID_FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign pop        = shf_out_eop_acc && !fifo_empty;

    // Round-robin scan starting at rr_ptr; modulo keeps non-power-of-2 NUM_REQ correct.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!pick_found && req_vld[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = IDW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        first_beat_d  = first_beat_q;
        push          = 1'b0;
        req_rdy       = '0;
        shf_vld       = 1'b0;
        shf_data_in   = '0;
        shf_sbcnt_hdr = 2'b00;
        shf_bcnt      = '0;
        shf_eop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found && !fifo_full) begin
                    grant_id_d = pick_id;
                    push       = 1'b1;
                    state_d    = XFER;
                end
            end
            XFER: begin
                shf_vld              = req_vld[grant_id_q];
                req_rdy[grant_id_q]  = shf_rdy;
                if (shf_vld) begin
                    shf_data_in   = req_data[int'(grant_id_q)*DIN_WIDTH +: DIN_WIDTH];
                    shf_bcnt      = req_bcnt[int'(grant_id_q)*DIN_BCNT +: DIN_BCNT];
                    shf_eop       = req_eop[grant_id_q];
                    shf_sbcnt_hdr = first_beat_q ? req_sbcnt_hdr[int'(grant_id_q)*2 +: 2] : 2'b00;
                end
                if (shf_vld && shf_rdy) begin
                    first_beat_d = 1'b0;
                    if (shf_eop) begin
                        first_beat_d = 1'b1;
                        rr_ptr_d     = next_rr(grant_id_q);
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            first_beat_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            first_beat_q <= first_beat_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CW'(1);
        end
    end

    // Data-only registers: meaningful only once the control state says so.
    always_ff @(posedge clk) begin
        grant_id_q <= grant_id_d;
        if (push) fifo_mem_q[wr_ptr_q] <= pick_id;
    end

    assign out_id     = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
    assign out_id_vld = !fifo_empty;
    assign busy       = (state_q == XFER);

endmodule

// File: tb/tb_shifter_req_arb.sv
// Directed bench for shifter_req_arb: a queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_shifter_req_arb;
    localparam int NR  = 4;
    localparam int DW  = 256;
    localparam int BW  = 6;
    localparam int IW  = 2;
    localparam int FD  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR*DW-1:0]   req_data;
    logic [NR*2-1:0]    req_sbcnt_hdr;
    logic [NR*BW-1:0]   req_bcnt;
    logic [NR-1:0]      req_eop, req_vld, req_rdy;
    logic [DW-1:0]      shf_data_in;
    logic [1:0]         shf_sbcnt_hdr;
    logic [BW-1:0]      shf_bcnt;
    logic               shf_eop, shf_vld, shf_rdy, shf_out_eop_acc;
    logic [IW-1:0]      out_id;
    logic               out_id_vld, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner (-1 = idle), round-robin start, first-beat flag, id queue.
    int m_owner = -1;
    int m_rr    = 0;
    bit m_first = 1'b1;
    int m_q[$];

    shifter_req_arb #(.NUM_REQ(NR), .DIN_WIDTH(DW), .DIN_BCNT(BW), .IDW(IW), .ID_FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_sbcnt_hdr(req_sbcnt_hdr),
        .req_bcnt(req_bcnt), .req_eop(req_eop), .req_vld(req_vld), .req_rdy(req_rdy),
        .shf_data_in(shf_data_in), .shf_sbcnt_hdr(shf_sbcnt_hdr), .shf_bcnt(shf_bcnt),
        .shf_eop(shf_eop), .shf_vld(shf_vld), .shf_rdy(shf_rdy),
        .shf_out_eop_acc(shf_out_eop_acc), .out_id(out_id), .out_id_vld(out_id_vld), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_check();
        logic [NR-1:0] e_rdy;
        logic          e_vld;
        logic [DW-1:0] e_data;
        logic [BW-1:0] e_bcnt;
        logic          e_eop;
        logic [1:0]    e_hdr;
        e_rdy = '0; e_vld = 1'b0; e_data = '0; e_bcnt = '0; e_eop = 1'b0; e_hdr = 2'b00;
        if (m_owner >= 0) begin
            e_rdy[m_owner] = shf_rdy;
            e_vld = req_vld[m_owner];
            if (e_vld) begin
                e_data = req_data[m_owner*DW +: DW];
                e_bcnt = req_bcnt[m_owner*BW +: BW];
                e_eop  = req_eop[m_owner];
                e_hdr  = m_first ? req_sbcnt_hdr[m_owner*2 +: 2] : 2'b00;
            end
        end
        chk("model req_rdy", DW'(req_rdy), DW'(e_rdy));
        chk("model shf_vld", DW'(shf_vld), DW'(e_vld));
        chk("model shf_data_in", shf_data_in, e_data);
        chk("model shf_bcnt", DW'(shf_bcnt), DW'(e_bcnt));
        chk("model shf_eop", DW'(shf_eop), DW'(e_eop));
        chk("model shf_sbcnt_hdr", DW'(shf_sbcnt_hdr), DW'(e_hdr));
        chk("model busy", DW'(busy), DW'(m_owner >= 0));
        chk("model out_id_vld", DW'(out_id_vld), DW'(m_q.size() > 0));
        if (m_q.size() > 0) chk("model out_id", DW'(out_id), DW'(m_q[0]));
    endtask

    task automatic model_step();
        bit do_pop, do_push, found;
        int push_id, c;
        if (rst) begin
            m_owner = -1; m_rr = 0; m_first = 1'b1; m_q.delete();
            return;
        end
        do_pop  = shf_out_eop_acc && (m_q.size() > 0);
        do_push = 1'b0; push_id = 0; found = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < NR; k++) begin
                c = (m_rr + k) % NR;
                if (!found && req_vld[c]) begin found = 1'b1; push_id = c; end
            end
            if (found && m_q.size() < FD) begin
                do_push = 1'b1;
                m_owner = push_id;
            end
        end else if (req_vld[m_owner] && shf_rdy) begin
            if (req_eop[m_owner]) begin
                m_rr    = (m_owner + 1) % NR;
                m_first = 1'b1;
                m_owner = -1;
            end else begin
                m_first = 1'b0;
            end
        end
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back(push_id);
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int r, input bit v, input int bc, input bit e,
                            input int hdr, input logic [31:0] tag);
        req_vld[r] = v;
        req_eop[r] = e;
        req_bcnt[r*BW +: BW] = BW'(bc);
        req_sbcnt_hdr[r*2 +: 2] = 2'(hdr);
        req_data[r*DW +: DW] = {8{tag}};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int ord [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1; req_data = '0; req_sbcnt_hdr = '0; req_bcnt = '0; req_eop = '0; req_vld = '0;
        shf_rdy = 1'b1; shf_out_eop_acc = 1'b0;
        do_reset();
        #1;
        chk("reset busy", DW'(busy), 0);
        chk("reset shf_vld", DW'(shf_vld), 0);
        chk("reset req_rdy", DW'(req_rdy), 0);
        chk("reset out_id_vld", DW'(out_id_vld), 0);

        // T1: three-beat packet from requester 0
        set_beat(0, 1, 32, 0, 3, 32'h1000_0001);
        tick(); #1;
        chk("T1 busy", DW'(busy), 1);
        chk("T1 hdr beat1", DW'(shf_sbcnt_hdr), 3);
        chk("T1 data beat1", shf_data_in, {8{32'h1000_0001}});
        chk("T1 out_id", DW'(out_id), 0);
        chk("T1 out_id_vld", DW'(out_id_vld), 1);
        tick();
        set_beat(0, 1, 32, 0, 3, 32'h1000_0002); #1;
        chk("T1 hdr beat2", DW'(shf_sbcnt_hdr), 0);
        tick();
        set_beat(0, 1, 5, 1, 3, 32'h1000_0003); #1;
        chk("T1 hdr beat3", DW'(shf_sbcnt_hdr), 0);
        chk("T1 bcnt beat3", DW'(shf_bcnt), 5);
        chk("T1 eop beat3", DW'(shf_eop), 1);
        tick();
        req_vld[0] = 1'b0; #1;
        chk("T1 idle after eop", DW'(busy), 0);
        chk("T1 out_id held", DW'(out_id), 0);
        chk("T1 out_id_vld held", DW'(out_id_vld), 1);
        shf_out_eop_acc = 1'b1;
        tick();
        shf_out_eop_acc = 1'b0; #1;
        chk("T1 fifo popped", DW'(out_id_vld), 0);

        // T2: all requesters valid, one-beat packets
        do_reset();
        for (int r = 0; r < NR; r++) set_beat(r, 1, 16, 1, 1, 32'h2000_0000 + r);
        shf_out_eop_acc = 1'b1;
        for (int p = 0; p < 5; p++) begin
            tick(); #1;
            chk("T2 grant", DW'(req_rdy), DW'(1 << ord[p]));
            chk("T2 data", shf_data_in, {8{32'h2000_0000 + ord[p]}});
            tick(); #1;
            chk("T2 bubble", DW'(busy), 0);
        end
        req_vld = '0;
        shf_out_eop_acc = 1'b0;

        // T3: ID FIFO full blocks grants until one pop
        do_reset();
        set_beat(0, 1, 8, 1, 0, 32'h3000_0000);
        tick(); tick(); tick(); tick(); #1;
        chk("T3 full busy", DW'(busy), 0);
        tick(); #1;
        chk("T3 full still idle", DW'(busy), 0);
        chk("T3 full req_rdy", DW'(req_rdy), 0);
        chk("T3 full out_id_vld", DW'(out_id_vld), 1);
        shf_out_eop_acc = 1'b1;
        tick();
        shf_out_eop_acc = 1'b0; #1;
        chk("T3 pop cycle no grant", DW'(busy), 0);
        tick(); #1;
        chk("T3 grant after pop", DW'(busy), 1);
        chk("T3 grant id", DW'(req_rdy), 1);
        tick();
        req_vld[0] = 1'b0;
        shf_out_eop_acc = 1'b1;
        tick(); tick();
        shf_out_eop_acc = 1'b0; #1;
        chk("T3 drained", DW'(out_id_vld), 0);

        // T4: granted requester 1 stalls mid-packet while requester 2 waits
        do_reset();
        shf_out_eop_acc = 1'b1;
        set_beat(1, 1, 32, 0, 2, 32'h4100_0001);
        set_beat(2, 1, 32, 1, 1, 32'h4200_0001);
        tick(); #1;
        chk("T4 grant 1", DW'(req_rdy), 4'b0010);
        tick();
        req_vld[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("T4 hold busy", DW'(busy), 1);
            chk("T4 hold req_rdy", DW'(req_rdy), 4'b0010);
            chk("T4 hold shf_vld", DW'(shf_vld), 0);
            tick();
        end
        set_beat(1, 1, 20, 1, 0, 32'h4100_0002); #1;
        chk("T4 resume data", shf_data_in, {8{32'h4100_0002}});
        chk("T4 resume hdr", DW'(shf_sbcnt_hdr), 0);
        chk("T4 resume bcnt", DW'(shf_bcnt), 20);
        tick();
        req_vld[1] = 1'b0;
        tick(); #1;
        chk("T4 grant 2", DW'(req_rdy), 4'b0100);
        chk("T4 hdr 2", DW'(shf_sbcnt_hdr), 1);
        tick();
        req_vld[2] = 1'b0;
        tick();
        shf_out_eop_acc = 1'b0;

        // T5: shifter backpressure on beat 2
        do_reset();
        shf_out_eop_acc = 1'b1;
        set_beat(0, 1, 32, 0, 2, 32'h5000_0001);
        tick(); tick();
        set_beat(0, 1, 32, 0, 2, 32'h5000_0002);
        shf_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("T5 stall req_rdy", DW'(req_rdy), 0);
            chk("T5 stall data", shf_data_in, {8{32'h5000_0002}});
            chk("T5 stall hdr", DW'(shf_sbcnt_hdr), 0);
            tick();
        end
        shf_rdy = 1'b1; #1;
        chk("T5 release req_rdy", DW'(req_rdy), 1);
        tick();
        set_beat(0, 1, 7, 1, 2, 32'h5000_0003);
        tick();
        req_vld[0] = 1'b0;
        tick();
        shf_out_eop_acc = 1'b0;

        // T6: reset in the middle of a packet
        do_reset();
        set_beat(0, 1, 32, 0, 3, 32'h6000_0001);
        tick(); tick();
        set_beat(0, 1, 32, 0, 3, 32'h6000_0002);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("T6 rst busy", DW'(busy), 0);
        chk("T6 rst out_id_vld", DW'(out_id_vld), 0);
        chk("T6 rst req_rdy", DW'(req_rdy), 0);
        set_beat(0, 1, 32, 0, 3, 32'h6000_0001);
        tick(); #1;
        chk("T6 regrant busy", DW'(busy), 1);
        chk("T6 regrant hdr", DW'(shf_sbcnt_hdr), 3);
        chk("T6 regrant data", shf_data_in, {8{32'h6000_0001}});
        tick();
        set_beat(0, 1, 4, 1, 3, 32'h6000_0002);
        tick();
        req_vld[0] = 1'b0;
        shf_out_eop_acc = 1'b1;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
